// File: rtl/if_instr_mem.sv
// IF-stage instruction memory: big-endian byte loader from the debug unit plus a registered fetch port.
// Optional load checksum output is enabled by defining IMEM_LOAD_CHECKSUM_EN.
module if_instr_mem #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [PC_WIDTH-1:0]   i_pc,
  output logic [INST_WIDTH-1:0] o_instr,
  output logic [PC_WIDTH-1:0]   o_pc_plus4,
  output logic                  o_instr_valid,
  output logic                  o_pc_oob,
  input  logic                  i_load_start,
  input  logic                  i_load_byte_valid,
  input  logic [7:0]            i_load_byte,
  input  logic                  i_load_end,
  output logic                  o_load_ready,
  output logic [ADDR_W:0]       o_load_words,
`ifdef IMEM_LOAD_CHECKSUM_EN
  output logic [7:0]            o_load_checksum,
`endif
  output logic                  o_load_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [PC_WIDTH:0] PC_LIMIT = (PC_WIDTH + 1)'(4 * MEM_DEPTH);

  state_e                state_r;
  logic [INST_WIDTH-1:0] mem_r [MEM_DEPTH];
  logic [INST_WIDTH-1:0] word_buf_r;
  logic [INST_WIDTH-1:0] word_s;
  logic [INST_WIDTH-1:0] rd_word_s;
  logic [INST_WIDTH-1:0] instr_r;
  logic [PC_WIDTH-1:0]   pc_plus4_r;
  logic [1:0]            byte_cnt_r;
  logic [1:0]            byte_cnt_s;
  logic [ADDR_W:0]       words_r;
  logic [ADDR_W:0]       words_next_s;
  logic [ADDR_W-1:0]     rd_addr_s;
  logic                  valid_r;
  logic                  oob_r;
  logic                  ready_r;
  logic                  ovf_r;
  logic                  full_s;
  logic                  accept_s;
  logic                  end_s;
  logic                  we_s;
  logic                  oob_s;

  // Byte assembly: merge the accepted byte into the word under construction and decide on a write
  always_comb begin
    full_s   = (words_r == DEPTH_W);
    accept_s = (state_r == ST_LOAD) && !i_load_start && i_load_byte_valid && !full_s;
    end_s    = (state_r == ST_LOAD) && !i_load_start && i_load_end;
    word_s   = (byte_cnt_r == 2'd0) ? '0 : word_buf_r;
    if (accept_s) begin
      case (byte_cnt_r)
        2'd0:    word_s[31:24] = i_load_byte;
        2'd1:    word_s[23:16] = i_load_byte;
        2'd2:    word_s[15:8]  = i_load_byte;
        default: word_s[7:0]   = i_load_byte;
      endcase
      byte_cnt_s = byte_cnt_r + 2'd1;
    end else begin
      byte_cnt_s = byte_cnt_r;
    end
    // A trailing partial word is flushed zero-padded when the load ends
    we_s         = (accept_s && (byte_cnt_r == 2'd3)) || (end_s && (byte_cnt_s != 2'd0));
    words_next_s = words_r + {{ADDR_W{1'b0}}, we_s};
  end

  // Fetch lookup: words past the loaded program or the array read back as NOP
  always_comb begin
    rd_addr_s = i_pc[ADDR_W+1:2];
    oob_s     = ({1'b0, rd_addr_s} >= words_r) || ({1'b0, i_pc} >= PC_LIMIT);
    if (oob_s) begin
      rd_word_s = '0;
    end else begin
      rd_word_s = mem_r[rd_addr_s];
    end
  end

  // Program storage write port (contents survive reset)
  always_ff @(posedge i_clk) begin
    if (we_s) begin
      mem_r[words_r[ADDR_W-1:0]] <= word_s;
    end
  end

  // Control FSM, load bookkeeping and registered fetch outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      word_buf_r <= '0;
      byte_cnt_r <= 2'd0;
      words_r    <= '0;
      ready_r    <= 1'b0;
      ovf_r      <= 1'b0;
      instr_r    <= '0;
      pc_plus4_r <= '0;
      valid_r    <= 1'b0;
      oob_r      <= 1'b0;
    end else if (i_load_start) begin
      state_r    <= ST_LOAD;
      word_buf_r <= '0;
      byte_cnt_r <= 2'd0;
      words_r    <= '0;
      ready_r    <= 1'b1;
      ovf_r      <= 1'b0;
      instr_r    <= '0;
      pc_plus4_r <= '0;
      valid_r    <= 1'b0;
      oob_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          word_buf_r <= word_s;
          words_r    <= words_next_s;
          if (i_load_byte_valid && full_s) begin
            ovf_r <= 1'b1;
          end
          if (end_s) begin
            state_r    <= ST_RUN;
            byte_cnt_r <= 2'd0;
            ready_r    <= 1'b0;
          end else begin
            byte_cnt_r <= byte_cnt_s;
            ready_r    <= (words_next_s != DEPTH_W);
          end
        end
        ST_RUN: begin
          // Flush outranks stall/enable; a held fetch keeps every output
          if (i_flush) begin
            instr_r <= '0;
            valid_r <= 1'b0;
            oob_r   <= 1'b0;
          end else if (i_enable && !i_stall) begin
            instr_r    <= rd_word_s;
            pc_plus4_r <= i_pc + PC_WIDTH'(4);
            valid_r    <= 1'b1;
            oob_r      <= oob_s;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          instr_r    <= '0;
          pc_plus4_r <= '0;
          valid_r    <= 1'b0;
          oob_r      <= 1'b0;
          ready_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0] csum_r;

  // XOR of accepted bytes since the last load start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csum_r <= 8'h00;
    end else if (i_load_start) begin
      csum_r <= 8'h00;
    end else if (accept_s) begin
      csum_r <= csum_r ^ i_load_byte;
    end
  end

  assign o_load_checksum = csum_r;
`endif

  assign o_instr       = instr_r;
  assign o_pc_plus4    = pc_plus4_r;
  assign o_instr_valid = valid_r;
  assign o_pc_oob      = oob_r;
  assign o_load_ready  = ready_r;
  assign o_load_words  = words_r;
  assign o_load_ovf    = ovf_r;

endmodule

// File: tb/tb_if_instr_mem.sv
// Scoreboard bench for if_instr_mem: a 256-word and a 4-word instance share all inputs.
module tb_if_instr_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, stall, flush;
  logic [31:0] pc;
  logic        load_start, bvalid, load_end;
  logic [7:0]  lbyte;

  logic [31:0] instr0, pc4_0, instr1, pc4_1;
  logic        valid0, oob0, ready0, ovf0, valid1, oob1, ready1, ovf1;
  logic [8:0]  words0;
  logic [2:0]  words1;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  csum0, csum1;
`endif

  typedef struct {
    string       name;
    int          due;
    int          kind;
    int          dut;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        oob;
    logic [31:0] words;
    logic        ready;
    logic        ovf;
    logic [7:0]  csum;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  if_instr_mem #(.PC_WIDTH(32), .INST_WIDTH(32), .MEM_DEPTH(256)) u_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_stall(stall), .i_flush(flush),
    .i_pc(pc), .o_instr(instr0), .o_pc_plus4(pc4_0), .o_instr_valid(valid0), .o_pc_oob(oob0),
    .i_load_start(load_start), .i_load_byte_valid(bvalid), .i_load_byte(lbyte),
    .i_load_end(load_end), .o_load_ready(ready0), .o_load_words(words0),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .o_load_checksum(csum0),
`endif
    .o_load_ovf(ovf0)
  );

  if_instr_mem #(.PC_WIDTH(32), .INST_WIDTH(32), .MEM_DEPTH(4)) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_stall(stall), .i_flush(flush),
    .i_pc(pc), .o_instr(instr1), .o_pc_plus4(pc4_1), .o_instr_valid(valid1), .o_pc_oob(oob1),
    .i_load_start(load_start), .i_load_byte_valid(bvalid), .i_load_byte(lbyte),
    .i_load_end(load_end), .o_load_ready(ready1), .o_load_words(words1),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .o_load_checksum(csum1),
`endif
    .o_load_ovf(ovf1)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    case (e.kind)
      0, 1: begin
        chk({e.name, ".instr"}, e.dut ? instr1 : instr0, e.instr);
        chk({e.name, ".valid"}, {31'd0, e.dut ? valid1 : valid0}, {31'd0, e.valid});
        if (e.kind == 0) begin
          chk({e.name, ".pc4"}, e.dut ? pc4_1 : pc4_0, e.pc4);
          chk({e.name, ".oob"}, {31'd0, e.dut ? oob1 : oob0}, {31'd0, e.oob});
        end
      end
      2: begin
        chk({e.name, ".words"}, e.dut ? {29'd0, words1} : {23'd0, words0}, e.words);
        chk({e.name, ".ready"}, {31'd0, e.dut ? ready1 : ready0}, {31'd0, e.ready});
        chk({e.name, ".ovf"}, {31'd0, e.dut ? ovf1 : ovf0}, {31'd0, e.ovf});
      end
      default: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
        chk({e.name, ".csum"}, {24'd0, e.dut ? csum1 : csum0}, {24'd0, e.csum});
`endif
      end
    endcase
  endtask

  // Monitor: compares every expectation due at this falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          checks++;
          fails++;
          $display("FAIL %s: stale expectation, due %0d seen at %0d", e.name, e.due, cyc);
        end else begin
          compare(e);
        end
      end
      cyc++;
    end
  end

  task automatic push(input string n, input int k, input int d, input logic [31:0] ins,
                      input logic [31:0] p4, input logic v, input logic o,
                      input logic [31:0] w, input logic r, input logic ov, input logic [7:0] cs);
    exp_t e;
    e.name = n; e.due = cyc; e.kind = k; e.dut = d;
    e.instr = ins; e.pc4 = p4; e.valid = v; e.oob = o;
    e.words = w; e.ready = r; e.ovf = ov; e.csum = cs;
    q.push_back(e);
  endtask

  task automatic exp_fetch(input string n, input int d, input logic [31:0] ins,
                           input logic [31:0] p4, input logic v, input logic o);
    push(n, 0, d, ins, p4, v, o, 32'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic exp_load(input string n, input int d, input logic [31:0] w,
                          input logic r, input logic ov);
    push(n, 2, d, 32'd0, 32'd0, 1'b0, 1'b0, w, r, ov, 8'h00);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1; clk1(); load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bvalid = 1'b1; lbyte = b; clk1(); bvalid = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1; clk1(); load_end = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] p);
    pc = p; clk1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog1 [8];
    prog1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0; enable = 1'b0; stall = 1'b0; flush = 1'b0; pc = 32'd0;
    load_start = 1'b0; bvalid = 1'b0; load_end = 1'b0; lbyte = 8'h00;
    exp_fetch("rst_fetch0", 0, 32'd0, 32'd0, 1'b0, 1'b0);
    exp_load("rst_load0", 0, 32'd0, 1'b0, 1'b0);
    exp_load("rst_load1", 1, 32'd0, 1'b0, 1'b0);
    clk1(); clk1();
    rst_n = 1'b1;
    clk1();

    // Two-word program, fetch 0 and 4
    pulse_start();
    exp_load("t1_start", 0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(prog1[i]);
    exp_load("t1_bytes", 0, 32'd2, 1'b1, 1'b0);
    pulse_end();
    exp_load("t1_end", 0, 32'd2, 1'b0, 1'b0);
    enable = 1'b1;
    fetch(32'd0);
    exp_fetch("t1_pc0", 0, 32'h2008_0005, 32'd4, 1'b1, 1'b0);
    fetch(32'd4);
    exp_fetch("t1_pc4", 0, 32'h0000_0000, 32'd8, 1'b1, 1'b0);
    enable = 1'b0;

    // Five bytes, last byte arrives with end -> zero-padded second word
    pulse_start();
    exp_fetch("t2_clear", 0, 32'd0, 32'd0, 1'b0, 1'b0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    bvalid = 1'b1; lbyte = 8'h11; load_end = 1'b1; clk1(); bvalid = 1'b0; load_end = 1'b0;
    exp_load("t2_end", 0, 32'd2, 1'b0, 1'b0);
    enable = 1'b1;
    fetch(32'd6);
    exp_fetch("t2_pc6", 0, 32'h1100_0000, 32'd10, 1'b1, 1'b0);
    fetch(32'd0);
    exp_fetch("t2_pc0", 0, 32'hAABB_CCDD, 32'd4, 1'b1, 1'b0);

    // Stall holds while pc moves; flush beats stall
    stall = 1'b1;
    fetch(32'd4);  exp_fetch("t3_stall1", 0, 32'hAABB_CCDD, 32'd4, 1'b1, 1'b0);
    fetch(32'd8);  exp_fetch("t3_stall2", 0, 32'hAABB_CCDD, 32'd4, 1'b1, 1'b0);
    fetch(32'd12); exp_fetch("t3_stall3", 0, 32'hAABB_CCDD, 32'd4, 1'b1, 1'b0);
    flush = 1'b1;
    clk1();
    push("t3_flush", 1, 0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h00);
    flush = 1'b0; stall = 1'b0;
    fetch(32'd4);
    exp_fetch("t3_resume", 0, 32'h1100_0000, 32'd8, 1'b1, 1'b0);

    // Out-of-range fetches, enable low holds, pc+4 wrap
    fetch(32'd8);
    exp_fetch("t4_oob", 0, 32'd0, 32'd12, 1'b1, 1'b1);
    enable = 1'b0;
    fetch(32'd0); exp_fetch("t4_hold1", 0, 32'd0, 32'd12, 1'b1, 1'b1);
    fetch(32'd4); exp_fetch("t4_hold2", 0, 32'd0, 32'd12, 1'b1, 1'b1);
    enable = 1'b1;
    fetch(32'h0000_0400);
    exp_fetch("t4_pclimit", 0, 32'd0, 32'h0000_0404, 1'b1, 1'b1);
    fetch(32'hFFFF_FFFC);
    exp_fetch("t4_wrap", 0, 32'd0, 32'd0, 1'b1, 1'b1);
    enable = 1'b0;

    // Overflow on the 4-word instance with 17 bytes
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      send(8'(i));
      if (i == 11) exp_load("t5_b12", 1, 32'd3, 1'b1, 1'b0);
      if (i == 15) exp_load("t5_b16", 1, 32'd4, 1'b0, 1'b0);
    end
    exp_load("t5_b17_small", 1, 32'd4, 1'b0, 1'b1);
    exp_load("t5_b17_big", 0, 32'd4, 1'b1, 1'b0);
    pulse_end();
    exp_load("t5_end_small", 1, 32'd4, 1'b0, 1'b1);
    exp_load("t5_end_big", 0, 32'd5, 1'b0, 1'b0);
    enable = 1'b1;
    fetch(32'd12);
    exp_fetch("t5_pc12_small", 1, 32'h0C0D_0E0F, 32'd16, 1'b1, 1'b0);
    fetch(32'd16);
    exp_fetch("t5_pc16_small", 1, 32'd0, 32'd20, 1'b1, 1'b1);
    exp_fetch("t5_pc16_big", 0, 32'h1000_0000, 32'd20, 1'b1, 1'b0);
    enable = 1'b0;

    // Asynchronous reset in the middle of a word
    pulse_start();
    exp_load("t6_start", 1, 32'd0, 1'b1, 1'b0);
    send(8'h01); send(8'h02);
    rst_n = 1'b0;
    exp_load("t6_arst_load", 0, 32'd0, 1'b0, 1'b0);
    exp_fetch("t6_arst_fetch", 0, 32'd0, 32'd0, 1'b0, 1'b0);
    clk1();
    rst_n = 1'b1;
    enable = 1'b1;
    fetch(32'd0);
    exp_fetch("t6_idle", 0, 32'd0, 32'd0, 1'b0, 1'b0);
    enable = 1'b0;
    pulse_start();
    send(8'h01); send(8'h02); send(8'h04);
    push("t6_csum", 3, 0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'h07);
    pulse_end();
    exp_load("t6_end", 0, 32'd1, 1'b0, 1'b0);
    enable = 1'b1;
    fetch(32'd0);
    exp_fetch("t6_pc0", 0, 32'h0102_0400, 32'd4, 1'b1, 1'b0);
    enable = 1'b0;

    clk1(); clk1(); clk1();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
